// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM demodulator: Q10 constants, the FSM state
// encoding and the Q10 multiply-dequantize used throughout the datapath.
package fm_demod_pkg;

    localparam int QUANT_BITS         = 10;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_GAIN       = 758;
    localparam int DEFAULT_QUAD1      = 804;

    // Operands are sign-extended to this width so one function serves any
    // sample width up to 64 bits.
    localparam int QMUL_WIDTH = 64;
    localparam int PROD_WIDTH = 2 * QMUL_WIDTH;
    localparam int ROUND_BIAS = (1 << QUANT_BITS) - 1;

    typedef enum logic [2:0] {
        READ,
        MULT,
        DIV_START,
        DIV_WAIT,
        ANGLE,
        WRITE
    } state_t;

    // Full-precision product divided by 1024 with truncation toward zero.
    // Negative products get a bias of 1023 before the arithmetic shift so the
    // shift rounds toward zero instead of toward minus infinity.
    function automatic logic signed [QMUL_WIDTH-1:0] qmul(
        input logic signed [QMUL_WIDTH-1:0] a,
        input logic signed [QMUL_WIDTH-1:0] b
    );
        logic signed [PROD_WIDTH-1:0] prod;
        logic signed [PROD_WIDTH-1:0] biased;
        prod   = a * b;
        biased = prod[PROD_WIDTH-1] ? (prod + PROD_WIDTH'(ROUND_BIAS)) : prod;
        return QMUL_WIDTH'(biased >>> QUANT_BITS);
    endfunction

endpackage

// File: rtl/fm_demod_if.sv
// FIFO-side bundle of the FM demodulator: the real/imag input FIFO heads and
// the demodulated output FIFO.
interface fm_demod_if #(
    parameter int DATA_WIDTH = 32
);

    logic signed [DATA_WIDTH-1:0] real_in;
    logic                         real_empty;
    logic                         real_rd_en;
    logic signed [DATA_WIDTH-1:0] imag_in;
    logic                         imag_empty;
    logic                         imag_rd_en;
    logic signed [DATA_WIDTH-1:0] demod_out;
    logic                         demod_wr_en;
    logic                         demod_full;

    // Environment side: owns the FIFOs.
    modport master (
        output real_in, real_empty, imag_in, imag_empty, demod_full,
        input  real_rd_en, imag_rd_en, demod_out, demod_wr_en
    );

    // Demodulator side.
    modport slave (
        input  real_in, real_empty, imag_in, imag_empty, demod_full,
        output real_rd_en, imag_rd_en, demod_out, demod_wr_en
    );

endinterface

// File: rtl/fm_demod_div_signed.sv
// Iterative signed divider: restoring division on magnitudes, one quotient
// bit per cycle, quotient truncated toward zero. done pulses for one cycle
// and the quotient then holds until the next start.
module div_signed #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] dividend,
    input  logic signed [DATA_WIDTH-1:0] divisor,
    output logic signed [DATA_WIDTH-1:0] quotient,
    output logic                         done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] ONE_U = DATA_WIDTH'(1);

    logic                  busy_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] rem_d;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] quo_d;
    logic [DATA_WIDTH-1:0] den_q;
    logic                  neg_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;

    // Magnitudes of the operands; the most negative value maps onto its
    // unsigned magnitude, which still fits in DATA_WIDTH bits.
    always_comb begin
        dividend_mag = dividend[DATA_WIDTH-1] ? (~dividend + ONE_U) : dividend;
        divisor_mag  = divisor[DATA_WIDTH-1]  ? (~divisor  + ONE_U) : divisor;
    end

    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, den_q};
        if (!trial[DATA_WIDTH]) begin
            rem_d = trial[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Load on start, then run DATA_WIDTH iterations and pulse done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(DATA_WIDTH);
            rem_q  <= '0;
            quo_q  <= dividend_mag;
            den_q  <= divisor_mag;
            neg_q  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient = neg_q ? -$signed(quo_q) : $signed(quo_q);
    assign done     = done_q;

endmodule

// File: rtl/fm_demod.sv
// FM demodulator: pops one complex sample from the real/imag FIFO pair,
// takes the quantized arctangent of its conjugate product with the previous
// sample, scales it by the demod gain and pushes one Q10 output sample.
module fm_demod
    import fm_demod_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GAIN       = DEFAULT_GAIN,
    parameter int QUAD1      = DEFAULT_QUAD1
) (
    input  logic         clock,
    input  logic         reset,
    fm_demod_if.slave    bus
);

    localparam int QUAD3 = 3 * QUAD1;
    localparam logic signed [DATA_WIDTH-1:0] GAIN_W  = DATA_WIDTH'(GAIN);
    localparam logic signed [DATA_WIDTH-1:0] QUAD1_W = DATA_WIDTH'(QUAD1);
    localparam logic signed [DATA_WIDTH-1:0] QUAD3_W = DATA_WIDTH'(QUAD3);
    localparam logic signed [DATA_WIDTH-1:0] ONE_S   = DATA_WIDTH'(1);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    state_t  state_q, state_d;
    sample_t real_q, real_d;
    sample_t imag_q, imag_d;
    sample_t prev_real_q, prev_real_d;
    sample_t prev_imag_q, prev_imag_d;
    sample_t x_q, x_d;
    sample_t y_q, y_d;
    sample_t abs_y_q, abs_y_d;
    sample_t r_q, r_d;
    sample_t result_q, result_d;

    sample_t angle_c;
    sample_t num_c;
    sample_t den_c;
    logic    rd_en_c;
    logic    wr_en_c;
    logic    div_start_c;
    sample_t div_quot;
    logic    div_done;

    // Q10 multiply at sample width: widen, multiply-dequantize, truncate.
    function automatic sample_t mulq(input sample_t a, input sample_t b);
        return DATA_WIDTH'(qmul(QMUL_WIDTH'(a), QMUL_WIDTH'(b)));
    endfunction

    // Divider operands: the sign of x picks which quadrant pair the ratio
    // describes; the +1 in abs_y keeps the denominator strictly positive.
    always_comb begin
        if (!x_q[DATA_WIDTH-1]) begin
            num_c = (x_q - abs_y_q) << QUANT_BITS;
            den_c = x_q + abs_y_q;
        end else begin
            num_c = (x_q + abs_y_q) << QUANT_BITS;
            den_c = abs_y_q - x_q;
        end
    end

    div_signed #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div (
        .clock   (clock),
        .reset   (reset),
        .start   (div_start_c),
        .dividend(num_c),
        .divisor (den_c),
        .quotient(div_quot),
        .done    (div_done)
    );

    // Next-state, datapath updates and FIFO strobes for each processing step.
    always_comb begin
        state_d     = state_q;
        real_d      = real_q;
        imag_d      = imag_q;
        prev_real_d = prev_real_q;
        prev_imag_d = prev_imag_q;
        x_d         = x_q;
        y_d         = y_q;
        abs_y_d     = abs_y_q;
        r_d         = r_q;
        result_d    = result_q;
        angle_c     = '0;
        rd_en_c     = 1'b0;
        wr_en_c     = 1'b0;
        div_start_c = 1'b0;

        case (state_q)
            READ: begin
                if (!reset && !bus.real_empty && !bus.imag_empty) begin
                    rd_en_c = 1'b1;
                    real_d  = bus.real_in;
                    imag_d  = bus.imag_in;
                    state_d = MULT;
                end
            end
            MULT: begin
                x_d         = mulq(prev_real_q, real_q) + mulq(prev_imag_q, imag_q);
                y_d         = mulq(prev_real_q, imag_q) - mulq(prev_imag_q, real_q);
                abs_y_d     = (y_d[DATA_WIDTH-1] ? -y_d : y_d) + ONE_S;
                prev_real_d = real_q;
                prev_imag_d = imag_q;
                state_d     = DIV_START;
            end
            DIV_START: begin
                div_start_c = 1'b1;
                state_d     = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_done) begin
                    r_d     = div_quot;
                    state_d = ANGLE;
                end
            end
            ANGLE: begin
                angle_c = (x_q[DATA_WIDTH-1] ? QUAD3_W : QUAD1_W) - mulq(QUAD1_W, r_q);
                if (y_q[DATA_WIDTH-1]) begin
                    angle_c = -angle_c;
                end
                result_d = mulq(GAIN_W, angle_c);
                state_d  = WRITE;
            end
            WRITE: begin
                if (!bus.demod_full) begin
                    wr_en_c = 1'b1;
                    state_d = READ;
                end
            end
            default: begin
                state_d = READ;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight sample and
    // clears the previous-sample history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= READ;
            real_q      <= '0;
            imag_q      <= '0;
            prev_real_q <= '0;
            prev_imag_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            abs_y_q     <= '0;
            r_q         <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            real_q      <= real_d;
            imag_q      <= imag_d;
            prev_real_q <= prev_real_d;
            prev_imag_q <= prev_imag_d;
            x_q         <= x_d;
            y_q         <= y_d;
            abs_y_q     <= abs_y_d;
            r_q         <= r_d;
            result_q    <= result_d;
        end
    end

    assign bus.real_rd_en  = rd_en_c;
    assign bus.imag_rd_en  = rd_en_c;
    assign bus.demod_wr_en = wr_en_c;
    assign bus.demod_out   = wr_en_c ? result_q : '0;

endmodule

// File: tb/tb_fm_demod.sv
// Directed testbench for fm_demod: a table of chained samples with
// hand-computed outputs, plus back-pressure, one-sided FIFO and mid-run
// reset sequences.
module tb_fm_demod;

    localparam int DW      = 32;
    localparam int LATENCY = DW + 5;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic signed [DW-1:0] expOut;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[7];

    fm_demod_if #(.DATA_WIDTH(DW)) bus ();

    fm_demod dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic signed [DW-1:0] actual,
                               input logic signed [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Offer one sample on both FIFOs, wait for the pop, then wait for the
    // single output pulse and check value, latency and absence of extra pops.
    task automatic applyStimulus(input string name, input logic signed [DW-1:0] re,
                                 input logic signed [DW-1:0] im,
                                 input logic signed [DW-1:0] expOut);
        bit popped;
        bit wrote;
        int cyc;
        int extraPops;
        @(negedge clock);
        bus.real_in    = re;
        bus.imag_in    = im;
        bus.real_empty = 1'b0;
        bus.imag_empty = 1'b0;
        popped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.real_rd_en) begin
                popped = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput({name, " pop"}, DW'(popped), DW'(1));
        checkOutput({name, " pairpop"}, DW'(bus.imag_rd_en), DW'(bus.real_rd_en));
        @(posedge clock);
        #1;
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        wrote     = 1'b0;
        cyc       = 0;
        extraPops = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (bus.real_rd_en || bus.imag_rd_en) extraPops++;
            if (bus.demod_wr_en) begin
                wrote = 1'b1;
                cyc   = i;
                break;
            end
        end
        checkOutput({name, " wrote"}, DW'(wrote), DW'(1));
        checkOutput({name, " latency"}, DW'(cyc), DW'(LATENCY));
        checkOutput({name, " value"}, bus.demod_out, expOut);
        checkOutput({name, " extrapops"}, DW'(extraPops), DW'(0));
        @(negedge clock);
        checkOutput({name, " onepulse"}, DW'(bus.demod_wr_en), DW'(0));
    endtask

    initial begin
        int holdBad;
        int popBad;
        bit popped;
        bit wrote;

        checks = 0;
        errors = 0;
        clock  = 1'b0;
        reset  = 1'b1;
        bus.real_in    = '0;
        bus.imag_in    = '0;
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        bus.demod_full = 1'b0;

        // Chained samples: each output depends on the previous table entry.
        vecs[0] = '{re: 1024,  im: 0,    expOut: 1190};
        vecs[1] = '{re: 1024,  im: 0,    expOut: 1};
        vecs[2] = '{re: 0,     im: 1024, expOut: 1190};
        vecs[3] = '{re: 1024,  im: 0,    expOut: -1190};
        vecs[4] = '{re: 512,   im: 512,  expOut: 595};
        vecs[5] = '{re: -1024, im: 0,    expOut: 1785};
        vecs[6] = '{re: 1024,  im: 0,    expOut: 2379};

        repeat (3) @(negedge clock);
        bus.real_empty = 1'b0;
        bus.imag_empty = 1'b0;
        #1;
        checkOutput("reset rd_en", DW'(bus.real_rd_en | bus.imag_rd_en), DW'(0));
        checkOutput("reset wr_en", DW'(bus.demod_wr_en), DW'(0));
        checkOutput("reset out", bus.demod_out, DW'(0));
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("idle rd_en", DW'(bus.real_rd_en | bus.imag_rd_en), DW'(0));

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].re, vecs[i].im, vecs[i].expOut);
        end

        // Back-pressure: output full well past the write point, FIFOs kept
        // non-empty to show nothing is popped while the result waits.
        @(negedge clock);
        bus.demod_full = 1'b1;
        bus.real_in    = 0;
        bus.imag_in    = -1024;
        bus.real_empty = 1'b0;
        bus.imag_empty = 1'b0;
        #1;
        popped = bus.real_rd_en && bus.imag_rd_en;
        checkOutput("full pop", DW'(popped), DW'(1));
        @(posedge clock);
        #1;
        holdBad = 0;
        popBad  = 0;
        for (int i = 1; i <= LATENCY + 20; i++) begin
            @(negedge clock);
            if (bus.demod_wr_en || bus.demod_out != 0) holdBad++;
            if (bus.real_rd_en || bus.imag_rd_en) popBad++;
        end
        checkOutput("full hold wr_en", DW'(holdBad), DW'(0));
        checkOutput("full hold pops", DW'(popBad), DW'(0));
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        bus.demod_full = 1'b0;
        #1;
        checkOutput("full release wr_en", DW'(bus.demod_wr_en), DW'(1));
        checkOutput("full release value", bus.demod_out, -DW'(1190));
        @(negedge clock);
        checkOutput("full release onepulse", DW'(bus.demod_wr_en), DW'(0));

        // Only one FIFO has data: neither may be popped.
        bus.real_in    = 1024;
        bus.real_empty = 1'b0;
        popBad = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.real_rd_en || bus.imag_rd_en) popBad++;
        end
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (bus.real_rd_en || bus.imag_rd_en) popBad++;
        end
        bus.imag_empty = 1'b1;
        checkOutput("onesided pops", DW'(popBad), DW'(0));

        // Reset while the divider is busy: the sample is dropped and the
        // history cleared, so the next (1024,0) behaves like the first one.
        @(negedge clock);
        bus.real_in    = 0;
        bus.imag_in    = 1024;
        bus.real_empty = 1'b0;
        bus.imag_empty = 1'b0;
        #1;
        checkOutput("divwait pop", DW'(bus.real_rd_en & bus.imag_rd_en), DW'(1));
        @(posedge clock);
        #1;
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        repeat (10) @(negedge clock);
        reset          = 1'b1;
        bus.real_in    = 1024;
        bus.imag_in    = 0;
        bus.real_empty = 1'b0;
        bus.imag_empty = 1'b0;
        #1;
        checkOutput("midreset rd_en", DW'(bus.real_rd_en | bus.imag_rd_en), DW'(0));
        checkOutput("midreset wr_en", DW'(bus.demod_wr_en), DW'(0));
        checkOutput("midreset out", bus.demod_out, DW'(0));
        @(negedge clock);
        bus.real_empty = 1'b1;
        bus.imag_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wrote = 1'b0;
        repeat (LATENCY + 5) begin
            @(negedge clock);
            if (bus.demod_wr_en) wrote = 1'b1;
        end
        checkOutput("midreset no stale write", DW'(wrote), DW'(0));
        applyStimulus("postreset", 1024, 0, 1190);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_demod.md
Name: fm_demod

Overview:
- Downstream neighbour of the complex channel FIR; consumes its real/imag FIFO pair.
- Per complex sample, forms the conjugate product with the previous sample and computes a Q10 quantized arctangent (qarctan) of it.
- Scales the angle by the demodulation gain and writes one signed Q10 sample to the demod output FIFO.
- Output feeds the audio-path FIRs.

Parameters:
- DATA_WIDTH, 32, sample width; all data signed two's complement Q10.
- GAIN, 758, demod gain in Q10, i.e. QUANTIZE(QUAD_RATE/(2*PI*MAX_DEV)).
- QUAD1, 804, PI/4 in Q10; QUAD3 is derived as 3*QUAD1 = 2412.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-high.
- real_in  in  DATA_WIDTH  real sample from FIFO head.
- real_empty  in  1  real FIFO empty.
- real_rd_en  out  1  pop real FIFO.
- imag_in  in  DATA_WIDTH  imag sample from FIFO head.
- imag_empty  in  1  imag FIFO empty.
- imag_rd_en  out  1  pop imag FIFO.
- demod_out  out  DATA_WIDTH  demodulated sample.
- demod_wr_en  out  1  push to output FIFO.
- demod_full  in  1  output FIFO full.

Behaviour:
- Reset (async, active-high): state=READ; prev_real, prev_imag, all datapath registers = 0. Outputs 0: real_rd_en, imag_rd_en, demod_wr_en, demod_out.
- Reset mid-operation abandons the in-flight sample. The next sample after reset uses prev=0.
- Q10 multiply = full 2*DATA_WIDTH signed product, divided by 1024 with truncation toward zero, then truncated to DATA_WIDTH. This is the shared functs multiply-dequantize; no saturation.
- READ:
  - When real_empty==0 AND imag_empty==0: assert real_rd_en and imag_rd_en together for exactly one cycle and latch both samples. Go to MULT.
  - Otherwise stay in READ with no rd_en. Never pop one FIFO without the other.
- MULT (1 cycle):
  - x = qmul(prev_real,real) + qmul(prev_imag,imag).
  - y = qmul(prev_real,imag) - qmul(prev_imag,real).
  - prev_real/prev_imag <= current sample.
  - abs_y = |y| + 1.
- DIV_START (1 cycle):
  - If x>=0: num = (x - abs_y)<<10, den = x + abs_y.
  - Else: num = (x + abs_y)<<10, den = abs_y - x.
  - den is always >0. Pulse start to the divider.
- DIV_WAIT: hold until the divider's done pulse.
  - Divider: signed num / positive den, restoring on magnitudes, DATA_WIDTH iterations, one bit per cycle.
  - Quotient r truncated toward zero. den==0 is unreachable and needs no handling.
- ANGLE (1 cycle):
  - angle = (x>=0 ? QUAD1 : QUAD3) - qmul(QUAD1, r).
  - Negate angle if y<0.
  - result = qmul(GAIN, angle).
- WRITE:
  - When demod_full==0: demod_wr_en=1 for one cycle, demod_out=result, go to READ.
  - When full: demod_wr_en=0 and state is held. demod_out is 0 whenever demod_wr_en=0.
- Throughput: one output per sample, no decimation.
- Latency READ-pop to write pulse = DATA_WIDTH+5 cycles (37 at default) when output not full.
- No input pops occur between READ and the completed WRITE, so back-pressure propagates upstream naturally.

Decomposition:
- functs package:
  - Q10 multiply-dequantize function.
  - QUANT_BITS=10 constant.
  - Default QUAD1/GAIN constants.
  - state enum {READ, MULT, DIV_START, DIV_WAIT, ANGLE, WRITE}.
- One sub-module, div_signed:
  - Ports: clock, reset, start, dividend, divisor, quotient, done.
  - Parameterised by DATA_WIDTH, iterative, reusable elsewhere in the chain.

Test Plan:
- Reset then sample (1024,0), prev=0: x=0, y=0, abs_y=1, r=-1024, angle=1608 -> demod_out=1190, wr_en pulse 37 cycles after pop.
- Next sample (1024,0): x=1024, y=0, r=1022, angle=2 -> demod_out=1.
- Next (0,1024) after (1024,0): y=1024, r=-1024, angle=1608 -> 1190.
- Next (1024,0) after (0,1024): y=-1024, angle=-1608 -> -1190 (truncation toward zero, not -1191).
- Hold demod_full=1 for 20 cycles at WRITE: demod_wr_en stays 0, no rd_en. Release -> single write of correct value, then READ.
- Only real FIFO non-empty: no rd_en on either FIFO. Assert reset during DIV_WAIT: outputs 0 immediately; next (1024,0) yields 1190 (prev cleared).
